// File: rtl/dmem_responder_if.sv
// dmem_responder_if: M-stage data-memory port between core (master) and responder (slave).
interface dmem_responder_if;
    logic        MemWriteM;
    logic        MemReadM;
    logic [2:0]  funct3M;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic [31:0] ReadData;
    modport master (output MemWriteM, MemReadM, funct3M, Mem_WrAddr, Mem_WrData, input ReadData);
    modport slave  (input MemWriteM, MemReadM, funct3M, Mem_WrAddr, Mem_WrData, output ReadData);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: byte-lane data memory with combinational extended loads, sticky fault capture and store counting.
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_responder_if.slave      bus,
    input  logic                 FaultClear,
    output logic                 MisalignFault,
    output logic [31:0]          FaultAddr,
    output logic [CNT_WIDTH-1:0] StoreCount
);
    logic [31:0]           memArray [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] wordIdx;
    logic [2:0]            f3;
    logic [1:0]            lane;
    logic                  storeLegal, loadLegal, storeCommit, faultEvent;
    logic [3:0]            byteEn;
    logic [31:0]           wrWord, rdWord;
    logic [7:0]            rdByte;
    logic [15:0]           rdHalf;

    assign wordIdx = bus.Mem_WrAddr[ADDR_WIDTH+1:2];
    assign f3      = bus.funct3M;
    assign lane    = bus.Mem_WrAddr[1:0];

    always_comb begin
        storeLegal  = (f3 == 3'b000) || (f3 == 3'b001 && !lane[0]) || (f3 == 3'b010 && lane == 2'b00);
        loadLegal   = (f3 == 3'b000) || (f3 == 3'b100) || ((f3 == 3'b001 || f3 == 3'b101) && !lane[0]) ||
                      (f3 == 3'b010 && lane == 2'b00);
        storeCommit = bus.MemWriteM && storeLegal;
        faultEvent  = (bus.MemWriteM && !storeLegal) || (bus.MemReadM && !loadLegal);
        byteEn      = f3[1] ? 4'b1111 : f3[0] ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b0001 << lane;
        wrWord      = f3[1] ? bus.Mem_WrData : f3[0] ? {2{bus.Mem_WrData[15:0]}} : {4{bus.Mem_WrData[7:0]}};
    end

    // Array has no reset so contents survive it; reset only blocks commits.
    always_ff @(posedge clk) begin
        if (reset && storeCommit)
            for (int i = 0; i < 4; i++)
                if (byteEn[i]) memArray[wordIdx][i*8 +: 8] <= wrWord[i*8 +: 8];
    end

    always_comb begin
        rdWord       = memArray[wordIdx];
        rdByte       = rdWord[{lane, 3'b000} +: 8];
        rdHalf       = lane[1] ? rdWord[31:16] : rdWord[15:0];
        bus.ReadData = !loadLegal ? 32'h0 :
                       f3[1]      ? rdWord :
                       f3[0]      ? {{16{!f3[2] && rdHalf[15]}}, rdHalf} :
                                    {{24{!f3[2] && rdByte[7]}}, rdByte};
    end

    // First fault wins, but a new event in a clear cycle re-arms with its address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            MisalignFault <= 1'b0;
            FaultAddr     <= 32'h0;
            StoreCount    <= '0;
        end else begin
            if (faultEvent) begin
                if (!MisalignFault || FaultClear) begin
                    MisalignFault <= 1'b1;
                    FaultAddr     <= bus.Mem_WrAddr;
                end
            end else if (FaultClear) begin
                MisalignFault <= 1'b0;
                FaultAddr     <= 32'h0;
            end
            if (storeCommit && StoreCount != {CNT_WIDTH{1'b1}})
                StoreCount <= StoreCount + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table plus reset and counter-saturation sequences.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clr = 1'b0, clr2 = 1'b0;
    logic        flt, flt2;
    logic [31:0] fa, fa2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    int          checks = 0, failures = 0;

    dmem_responder_if bus();
    dmem_responder_if bus2();

    dmem_responder #(.ADDR_WIDTH(10), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .FaultClear(clr),
        .MisalignFault(flt), .FaultAddr(fa), .StoreCount(cnt));

    dmem_responder #(.ADDR_WIDTH(10), .CNT_WIDTH(2)) dutSat (
        .clk(clk), .reset(reset), .bus(bus2), .FaultClear(clr2),
        .MisalignFault(flt2), .FaultAddr(fa2), .StoreCount(cnt2));

    always #5 clk = ~clk;

    typedef struct {
        logic        we, re;
        logic [2:0]  f3;
        logic [31:0] addr, wd;
        logic        fc, chkRd;
        logic [31:0] rd;
        logic        flt;
        logic [31:0] fa;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic re, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                                logic fc, logic chkRd, logic [31:0] rd, logic fl, logic [31:0] fad, logic [15:0] cn);
        vec_t v;
        v.we = we; v.re = re; v.f3 = f3; v.addr = addr; v.wd = wd; v.fc = fc;
        v.chkRd = chkRd; v.rd = rd; v.flt = fl; v.fa = fad; v.cnt = cn;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(logic we, logic re, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd, logic fc);
        bus.MemWriteM = we; bus.MemReadM = re; bus.funct3M = f3;
        bus.Mem_WrAddr = addr; bus.Mem_WrData = wd; clr = fc;
    endtask

    initial begin
        drive(0, 0, 3'b010, 0, 0, 0);
        bus2.MemWriteM = 0; bus2.MemReadM = 0; bus2.funct3M = 3'b010;
        bus2.Mem_WrAddr = 0; bus2.Mem_WrData = 0;
        //            we re f3      addr   wdata        clr chk rd           flt fa     cnt
        vecs.push_back(mk(1, 0, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h0,  1));
        vecs.push_back(mk(0, 1, 3'b010, 32'h10, 32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h0,  1));
        vecs.push_back(mk(1, 0, 3'b000, 32'h13, 32'h12,       0, 1, 32'hFFFFFFDE, 0, 32'h0,  2));
        vecs.push_back(mk(0, 1, 3'b010, 32'h10, 32'h0,        0, 1, 32'h12ADBEEF, 0, 32'h0,  2));
        vecs.push_back(mk(0, 1, 3'b000, 32'h13, 32'h0,        0, 1, 32'h00000012, 0, 32'h0,  2));
        vecs.push_back(mk(0, 1, 3'b000, 32'h12, 32'h0,        0, 1, 32'hFFFFFFAD, 0, 32'h0,  2));
        vecs.push_back(mk(0, 1, 3'b100, 32'h12, 32'h0,        0, 1, 32'h000000AD, 0, 32'h0,  2));
        vecs.push_back(mk(0, 1, 3'b001, 32'h12, 32'h0,        0, 1, 32'h000012AD, 0, 32'h0,  2));
        vecs.push_back(mk(1, 0, 3'b001, 32'h10, 32'h8001,     0, 1, 32'hFFFFBEEF, 0, 32'h0,  3));
        vecs.push_back(mk(0, 1, 3'b101, 32'h10, 32'h0,        0, 1, 32'h00008001, 0, 32'h0,  3));
        vecs.push_back(mk(0, 1, 3'b001, 32'h10, 32'h0,        0, 1, 32'hFFFF8001, 0, 32'h0,  3));
        vecs.push_back(mk(0, 1, 3'b010, 32'h10, 32'h0,        0, 1, 32'h12AD8001, 0, 32'h0,  3));
        vecs.push_back(mk(1, 0, 3'b010, 32'h20, 32'hCAFEF00D, 0, 0, 32'h0,        0, 32'h0,  4));
        vecs.push_back(mk(0, 0, 3'b001, 32'h31, 32'h0,        0, 1, 32'h0,        0, 32'h0,  4));
        vecs.push_back(mk(1, 0, 3'b010, 32'h22, 32'h11111111, 0, 1, 32'h0,        1, 32'h22, 4));
        vecs.push_back(mk(0, 1, 3'b010, 32'h20, 32'h0,        0, 1, 32'hCAFEF00D, 1, 32'h22, 4));
        vecs.push_back(mk(0, 1, 3'b001, 32'h31, 32'h0,        0, 1, 32'h0,        1, 32'h22, 4));
        vecs.push_back(mk(0, 0, 3'b010, 32'h0,  32'h0,        1, 0, 32'h0,        0, 32'h0,  4));
        vecs.push_back(mk(1, 0, 3'b011, 32'h24, 32'hFF,       0, 1, 32'h0,        1, 32'h24, 4));
        vecs.push_back(mk(0, 0, 3'b010, 32'h0,  32'h0,        1, 0, 32'h0,        0, 32'h0,  4));
        vecs.push_back(mk(1, 0, 3'b010, 32'h22, 32'h11111111, 0, 1, 32'h0,        1, 32'h22, 4));
        vecs.push_back(mk(0, 1, 3'b010, 32'h45, 32'h0,        1, 1, 32'h0,        1, 32'h45, 4));
        vecs.push_back(mk(0, 1, 3'b010, 32'h20, 32'h0,        0, 1, 32'hCAFEF00D, 1, 32'h45, 4));
        vecs.push_back(mk(1, 0, 3'b010, 32'h40, 32'hAAAAAAAA, 0, 0, 32'h0,        1, 32'h45, 5));
        vecs.push_back(mk(1, 1, 3'b010, 32'h40, 32'h55555555, 0, 1, 32'hAAAAAAAA, 1, 32'h45, 6));
        vecs.push_back(mk(0, 1, 3'b010, 32'h40, 32'h0,        0, 1, 32'h55555555, 1, 32'h45, 6));
        vecs.push_back(mk(1, 0, 3'b010, 32'h50, 32'h0BADF00D, 0, 0, 32'h0,        1, 32'h45, 7));
        vecs.push_back(mk(0, 1, 3'b110, 32'h50, 32'h0,        0, 1, 32'h0,        1, 32'h45, 7));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_fault", {31'b0, flt}, 32'h0);
        chk("reset_faddr", fa, 32'h0);
        chk("reset_count", {16'b0, cnt}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].re, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].fc);
            #1;
            if (vecs[i].chkRd) chk($sformatf("v%0d_rdata", i), bus.ReadData, vecs[i].rd);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_fault", i), {31'b0, flt}, {31'b0, vecs[i].flt});
            chk($sformatf("v%0d_faddr", i), fa, vecs[i].fa);
            chk($sformatf("v%0d_count", i), {16'b0, cnt}, {16'b0, vecs[i].cnt});
        end

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(0, 0, 3'b010, 0, 0, 0);
            bus2.MemWriteM = 1; bus2.funct3M = 3'b010;
            bus2.Mem_WrAddr = 32'(i * 4); bus2.Mem_WrData = 32'(i);
            @(posedge clk);
            #1;
            chk($sformatf("sat_count%0d", i), {30'b0, cnt2}, (i < 3) ? 32'(i + 1) : 32'd3);
        end

        @(negedge clk);
        bus2.MemWriteM = 0;
        drive(1, 0, 3'b010, 32'h50, 32'h12345678, 0);
        reset = 1'b0;
        #1;
        chk("async_rst_fault", {31'b0, flt}, 32'h0);
        chk("async_rst_faddr", fa, 32'h0);
        chk("async_rst_count", {16'b0, cnt}, 32'h0);
        chk("async_rst_satcount", {30'b0, cnt2}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_edge_count", {16'b0, cnt}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1, 3'b010, 32'h50, 0, 0);
        #1;
        chk("rst_nowrite_0x50", bus.ReadData, 32'h0BADF00D);
        bus.Mem_WrAddr = 32'h10;
        #1;
        chk("rst_preserve_0x10", bus.ReadData, 32'h12AD8001);
        @(posedge clk);
        #1;
        chk("post_rst_count", {16'b0, cnt}, 32'h0);
        chk("post_rst_fault", {31'b0, flt}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined core's M-stage memory port: the slave end of the Mem_WrAddr / Mem_WrData / MemWriteM / funct3M / ReadData interface.
- Commits SB/SH/SW with byte-lane enables.
- Returns LB/LH/LW/LBU/LHU data combinationally, with sign or zero extension, so the M/W pipeline register captures it at the same edge.
- Detects misaligned and illegal accesses, latches the first faulting address, and counts committed stores.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array depth = 2^ADDR_WIDTH 32-bit words (4 KiB at default).
- CNT_WIDTH, 16, width of StoreCount.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemWriteM  in  1  store request this cycle.
- MemReadM  in  1  load request this cycle.
- funct3M  in  3  access size/sign code (RV32I load/store funct3).
- Mem_WrAddr  in  32  byte address for loads and stores.
- Mem_WrData  in  32  store data, right-aligned.
- FaultClear  in  1  clears sticky fault on next edge.
- ReadData  out  32  extended load data (combinational).
- MisalignFault  out  1  sticky fault flag.
- FaultAddr  out  32  byte address of first fault since last clear.
- StoreCount  out  CNT_WIDTH  number of committed stores, saturating.

Behaviour:
- Reset (reset=0, async): MisalignFault=0, FaultAddr=0, StoreCount=0. Array contents are not reset and are preserved across reset. No store commits while reset=0, including a store in the cycle reset asserts.
- Word index = Mem_WrAddr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so the array aliases.
- Store legality:
  - funct3 000 (SB): always legal.
  - funct3 001 (SH): legal if addr[0]=0.
  - funct3 010 (SW): legal if addr[1:0]=00.
  - Any other funct3: illegal.
- Store commit: on a rising edge with MemWriteM=1 and legal:
  - SB writes byte lane addr[1:0] with WrData[7:0].
  - SH writes lanes {addr[1],1} and {addr[1],0} with WrData[15:0], little-endian.
  - SW writes all lanes.
  - Unselected lanes are unchanged.
  - An illegal or misaligned store writes nothing.
- Load decode (combinational, every cycle, independent of MemReadM):
  - Read word W = array[index].
  - LB/LBU select byte addr[1:0].
  - LH/LHU select half addr[1] and require addr[0]=0.
  - LW requires addr[1:0]=00.
  - 000 and 001 sign-extend; 100 and 101 zero-extend.
  - Misaligned or illegal funct3 (011, 110, 111) → ReadData=0.
- Read-during-write: when MemReadM and MemWriteM are high in the same cycle, ReadData shows pre-write contents. The new data is visible from the next cycle.
- Fault detect: a fault event is any of:
  - (MemWriteM=1 and store illegal/misaligned), or
  - (MemReadM=1 and load illegal/misaligned).
  - If both requests fault in the same cycle, a single event is recorded with the same address.
- Fault latch, on the rising edge:
  - If event and MisalignFault=0: MisalignFault←1, FaultAddr←Mem_WrAddr.
  - If event and MisalignFault=1: FaultAddr is held (first fault wins), unless FaultClear=1 in the same cycle. In that case the new event is captured (set beats clear).
  - If FaultClear=1 and no event: MisalignFault←0, FaultAddr←0.
- StoreCount increments by 1 on each committed store and saturates at all-ones. Faulting stores are not counted.
- No backpressure; every access completes in the cycle presented. Zero-latency read, one-edge write.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF; next cycle LW 0x10 → ReadData=0xDEADBEEF, StoreCount=1, MisalignFault=0.
- Byte and half lanes on word 0x10=0xDEADBEEF:
  - SB 0x13 data 0x00000012 → LW 0x10 = 0x12ADBEEF.
  - LB 0x13 = 0x00000012.
  - LB 0x12 = 0xFFFFFFAD; LBU 0x12 = 0x000000AD.
  - LH 0x12 = 0x000012AD.
  - SH 0x10 data 0x8001 → LHU 0x10 = 0x00008001, LH 0x10 = 0xFFFF8001.
- Misalignment:
  - SW 0x22 data 0x11111111 → no write, StoreCount unchanged, MisalignFault=1, FaultAddr=0x22.
  - Then LH 0x31 (MemReadM=1) → ReadData=0, FaultAddr stays 0x22.
  - FaultClear → MisalignFault=0, FaultAddr=0.
- Clear/event collision: with fault set at 0x22, assert FaultClear together with LW 0x45 → MisalignFault=1, FaultAddr=0x45.
- Read-during-write: word 0x40=0xAAAAAAAA; same cycle SW 0x40 data 0x55555555 and LW 0x40 → ReadData=0xAAAAAAAA that cycle, 0x55555555 next cycle.
- Reset mid-operation:
  - Drive reset=0 while presenting SW 0x50 data 0x12345678 → no write, all outputs 0.
  - After release, LW 0x10 still returns prior contents (array preserved).
  - With CNT_WIDTH=2, four committed stores → StoreCount=3 (saturated).
